// File: rtl/mux_sel_scanner_if.sv
// rtl/mux_sel_scanner_if.sv - control/status bundle between a scan controller and mux_sel_scanner
interface mux_sel_scanner_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [3:0]         ch_en;
    logic [DWELL_W-1:0] dwell;
    logic               s1;
    logic               s0;
    logic               sel_valid;
    logic               ch_step;
    logic               scan_wrap;
    logic               busy;

    modport master (
        output start, stop, ch_en, dwell,
        input  s1, s0, sel_valid, ch_step, scan_wrap, busy
    );

    modport slave (
        input  start, stop, ch_en, dwell,
        output s1, s0, sel_valid, ch_step, scan_wrap, busy
    );
endinterface

// File: rtl/mux_sel_scanner.sv
// rtl/mux_sel_scanner.sv - round-robin select generator for a 4:1 mux with skip, dwell and wrap flag
module mux_sel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_sel_scanner_if.slave      bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               ch_step_q, ch_step_d;
    logic               scan_wrap_q, scan_wrap_d;

    logic [1:0]         first_idx;
    logic [1:0]         next_idx;
    logic [1:0]         cand;

    // Lowest enabled channel: iterate downward so the smallest set bit wins.
    always_comb begin
        first_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.ch_en[k]) first_idx = 2'(k);
        end
    end

    // Next enabled channel after idx_q; offset 4 wraps back onto idx_q itself.
    always_comb begin
        next_idx = idx_q;
        cand     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = idx_q + 2'(k);
            if (bus.ch_en[cand]) next_idx = cand;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ch_step_d   = 1'b0;
        scan_wrap_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.ch_en != 4'd0)) begin
                    state_d   = DWELL;
                    idx_d     = first_idx;
                    cnt_d     = bus.dwell;
                    ch_step_d = 1'b1;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (bus.ch_en == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    idx_d       = next_idx;
                    cnt_d       = bus.dwell;
                    ch_step_d   = 1'b1;
                    scan_wrap_d = (next_idx <= idx_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            ch_step_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ch_step_q   <= ch_step_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign bus.s1        = idx_q[1];
    assign bus.s0        = idx_q[0];
    assign bus.sel_valid = (state_q == DWELL);
    assign bus.busy      = (state_q == DWELL);
    assign bus.ch_step   = ch_step_q;
    assign bus.scan_wrap = scan_wrap_q;
endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb/tb_mux_sel_scanner.sv - scoreboard bench for mux_sel_scanner with a visit-level reference model
module tb_mux_sel_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_sel_scanner_if #(.DWELL_W(8)) bus ();

    mux_sel_scanner #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] s;
        logic       v;
        logic       st;
        logic       wr;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Mux inputs i0..i3 = 0,1,0,1
    logic [3:0] mux_in = 4'b1010;
    logic       y;
    assign y = mux_in[{bus.s1, bus.s0}];

    // Reference model: whether a scan is running, the channel, and position within the visit.
    bit m_active = 0;
    int m_ch     = 0;
    int m_pos    = 0;
    int m_len    = 1;

    function automatic int lowest(input logic [3:0] en);
        for (int k = 0; k < 4; k++) if (en[k]) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive_cycle(input logic st, input logic sp, input logic [3:0] en, input logic [7:0] dw);
        exp_t e;
        int   nxt;
        @(negedge clk);
        bus.start = st;
        bus.stop  = sp;
        bus.ch_en = en;
        bus.dwell = dw;
        e.st = 1'b0;
        e.wr = 1'b0;
        if (!m_active) begin
            if (st && !sp && en != 4'd0) begin
                m_ch     = lowest(en);
                m_active = 1;
                m_pos    = 0;
                m_len    = int'(dw) + 1;
                e.st     = 1'b1;
            end
        end else if (sp) begin
            m_active = 0;
        end else if (m_pos + 1 < m_len) begin
            m_pos++;
        end else begin
            nxt = -1;
            for (int off = 1; off <= 4; off++)
                if (nxt < 0 && en[(m_ch + off) % 4]) nxt = (m_ch + off) % 4;
            if (nxt < 0) begin
                m_active = 0;
            end else begin
                e.st  = 1'b1;
                e.wr  = (nxt <= m_ch);
                m_ch  = nxt;
                m_pos = 0;
                m_len = int'(dw) + 1;
            end
        end
        e.s = 2'(m_ch);
        e.v = m_active;
        e.b = m_active;
        sb.push_back(e);
    endtask

    // Monitor: every post-edge sample with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if ({bus.s1, bus.s0} !== e.s || bus.sel_valid !== e.v || bus.ch_step !== e.st ||
                    bus.scan_wrap !== e.wr || bus.busy !== e.b || y !== mux_in[e.s]) begin
                    fails++;
                    $display("FAIL cycle %0d: got s=%b v=%b step=%b wrap=%b busy=%b y=%b want s=%b v=%b step=%b wrap=%b busy=%b y=%b",
                             cyc, {bus.s1, bus.s0}, bus.sel_valid, bus.ch_step, bus.scan_wrap, bus.busy, y,
                             e.s, e.v, e.st, e.wr, e.b, mux_in[e.s]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 0;
        bus.stop  = 0;
        bus.ch_en = 4'd0;
        bus.dwell = 8'd0;
        #12;
        chk("reset_s1s0", {6'd0, bus.s1, bus.s0}, 8'd0);
        chk("reset_sel_valid", {7'd0, bus.sel_valid}, 8'd0);
        chk("reset_busy", {7'd0, bus.busy}, 8'd0);
        chk("reset_ch_step", {7'd0, bus.ch_step}, 8'd0);
        chk("reset_scan_wrap", {7'd0, bus.scan_wrap}, 8'd0);
        @(negedge clk);
        rst = 0;

        // Full scan, dwell 0
        repeat (10) drive_cycle(1, 0, 4'b1111, 8'd0);
        drive_cycle(0, 1, 4'b1111, 8'd0);
        // Skipping with dwell 2
        repeat (14) drive_cycle(1, 0, 4'b1010, 8'd2);
        drive_cycle(0, 1, 4'b1010, 8'd2);
        // Single channel, dwell 1
        repeat (9) drive_cycle(1, 0, 4'b0100, 8'd1);
        drive_cycle(0, 1, 4'b0100, 8'd1);
        // Stop mid-dwell on channel 2
        repeat (3) drive_cycle(1, 0, 4'b0100, 8'd5);
        drive_cycle(0, 1, 4'b0100, 8'd5);
        repeat (3) drive_cycle(0, 0, 4'b0100, 8'd5);
        // ch_en cleared mid-dwell
        repeat (2) drive_cycle(1, 0, 4'b1111, 8'd4);
        repeat (8) drive_cycle(0, 0, 4'b0000, 8'd4);
        // Start with nothing enabled, then start with stop
        repeat (3) drive_cycle(1, 0, 4'b0000, 8'd0);
        repeat (3) drive_cycle(1, 1, 4'b1111, 8'd0);
        drive_cycle(0, 0, 4'b1111, 8'd0);

        // Randomized traffic with mid-dwell ch_en/dwell changes
        begin
            logic [3:0] en;
            en = 4'($urandom);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 7) == 0) en = 4'($urandom);
                drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                            en, 8'($urandom_range(0, 3)));
            end
        end
        drive_cycle(0, 1, 4'b0000, 8'd0);

        // Asynchronous reset while dwelling on channel 3
        repeat (4) drive_cycle(1, 0, 4'b1000, 8'd7);
        @(posedge clk);
        #3;
        chk("pre_reset_channel", {6'd0, bus.s1, bus.s0}, 8'd3);
        rst = 1;
        #1;
        chk("async_rst_s1s0", {6'd0, bus.s1, bus.s0}, 8'd0);
        chk("async_rst_sel_valid", {7'd0, bus.sel_valid}, 8'd0);
        chk("async_rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("async_rst_ch_step", {7'd0, bus.ch_step}, 8'd0);
        m_active = 0;
        m_ch     = 0;
        bus.start = 0;
        @(negedge clk);
        rst = 0;
        repeat (8) drive_cycle(1, 0, 4'b0110, 8'd1);
        repeat (2) drive_cycle(0, 1, 4'b0110, 8'd1);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream select generator for the 4:1 mux (`MUX_4to1`, ports i0..i3, s1, s0, Y).
- Drives s1/s0 so the mux scans its four inputs in round-robin order.
- Skips channels that are disabled, holds each selected channel for a programmable dwell time, and flags every scan wrap.
- Lets a downstream sampler capture Y once per channel visit.

Parameters:
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a scan when idle.
- stop  input  1  level-sampled; ends the scan and returns to idle.
- ch_en  input  4  per-channel enable; bit k enables mux input ik.
- dwell  input  DWELL_W  hold time per channel, minus one (0 means 1 cycle).
- s1  output  1  mux select MSB; registered.
- s0  output  1  mux select LSB; registered.
- sel_valid  output  1  high while s1/s0 point at an enabled channel being dwelt on.
- ch_step  output  1  one-cycle pulse in the first cycle of each channel visit.
- scan_wrap  output  1  one-cycle pulse when the new channel index is <= the previous one (wrap or single-channel repeat).
- busy  output  1  high in the DWELL state.

Behaviour:
- Reset (asynchronous, any time):
  - State goes to IDLE; dwell counter = 0.
  - s1 = 0, s0 = 0, sel_valid = 0, ch_step = 0, scan_wrap = 0, busy = 0.
  - Reset mid-scan aborts immediately; no pulse is emitted.
- States are IDLE and DWELL. Channel index idx = {s1, s0}.
- IDLE:
  - If start = 1, stop = 0 and ch_en != 0: load idx with the lowest set bit of ch_en, load counter = dwell, go to DWELL.
  - In that next cycle: sel_valid = 1, busy = 1, ch_step = 1, scan_wrap = 0.
  - If start = 1 and ch_en = 0: stay in IDLE, all outputs low.
  - s1/s0 hold their last value in IDLE.
- DWELL, counter != 0: decrement the counter, hold idx. ch_step = 0, scan_wrap = 0.
- DWELL, counter = 0 (last cycle of the visit):
  - Sample ch_en. Search idx+1, idx+2, idx+3, idx+4 (mod 4); the first enabled entry becomes the next idx.
  - Reload counter from dwell (dwell is sampled per visit).
  - Pulse ch_step in the next cycle.
  - Pulse scan_wrap in the same next cycle if next idx <= old idx. A single enabled channel therefore pulses scan_wrap on every revisit.
  - If ch_en = 0 at this point: go to IDLE; sel_valid = 0, busy = 0, no pulses.
- Visit length: exactly dwell+1 cycles with sel_valid = 1 per visit.
- Latency: start-to-first-valid-select is 1 cycle.
- stop = 1 in DWELL: go to IDLE next cycle; sel_valid = 0, busy = 0, no pulses; s1/s0 hold.
  - stop has priority over a simultaneous advance.
  - stop = 1 together with start = 1 in IDLE: stay in IDLE.
- start is ignored while in DWELL.
- Changes to ch_en mid-dwell take effect only at the next advance.
- Changes to dwell mid-dwell take effect only at the next reload.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
- Full scan:
  - Stimulus: rst pulse, ch_en = 4'b1111, dwell = 0, start = 1 held.
  - Response: s1s0 = 00, 01, 10, 11, 00, … one per cycle; ch_step = 1 every cycle; scan_wrap = 1 only on each 11->00 step; with mux inputs i0..i3 = 0,1,0,1, Y toggles 0,1,0,1.
- Skipping and dwell:
  - Stimulus: ch_en = 4'b1010, dwell = 2.
  - Response: first select 01, held 3 cycles; then 11, held 3 cycles; then 01 with scan_wrap = 1; ch_step pulses once per 3 cycles.
- Single channel:
  - Stimulus: ch_en = 4'b0100, dwell = 1.
  - Response: s1s0 stays 10; ch_step and scan_wrap both pulse every 2 cycles.
- Stop and disable:
  - Stimulus: stop = 1 asserted mid-dwell on channel 2.
  - Response: next cycle sel_valid = 0, busy = 0, s1s0 stays 10, no pulses.
  - Stimulus (separately): ch_en cleared to 0 mid-dwell.
  - Response: scan continues to the end of that dwell, then drops to IDLE.
- Start with nothing enabled / priority:
  - Stimulus: start = 1 with ch_en = 0.
  - Response: busy stays 0.
  - Stimulus: start = 1 and stop = 1 in the same cycle.
  - Response: stays in IDLE.
- Asynchronous reset:
  - Stimulus: rst asserted between clock edges during a scan on channel 3.
  - Response: s1s0 = 00, sel_valid = 0, busy = 0 immediately, without waiting for a clock edge.
  - Stimulus: rst released, then start.
  - Response: scan restarts at the lowest enabled channel.
